// File: rtl/packet_mem_arbiter.sv
// Three-way arbiter sharing a single-port packet memory between RX (writes),
// TX (reads) and a host port, with a starvation guard for the host.
module packet_mem_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 16,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              rx_req,
    input  logic              tx_req,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] rx_wdata,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_we,
    output logic              rx_gnt,
    output logic              tx_gnt,
    output logic              host_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              tx_rvalid,
    output logic              host_rvalid
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_TX   = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

    logic [7:0] host_wait_cnt;
    logic       last_host;
    tag_t       tag_s1;

    // Starved host beats RX; otherwise RX first, then TX/host round-robin.
    always_comb begin
        rx_gnt   = 1'b0;
        tx_gnt   = 1'b0;
        host_gnt = 1'b0;
        if (reset_n) begin
            if (host_req && host_wait_cnt >= MAX_WAIT)
                host_gnt = 1'b1;
            else if (rx_req)
                rx_gnt = 1'b1;
            else if (tx_req && (!host_req || last_host))
                tx_gnt = 1'b1;
            else if (host_req)
                host_gnt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            host_wait_cnt <= 8'd0;
            last_host     <= 1'b1;
            tag_s1        <= TAG_NONE;
            tx_rvalid     <= 1'b0;
            host_rvalid   <= 1'b0;
        end else begin
            mem_en <= rx_gnt | tx_gnt | host_gnt;
            mem_we <= rx_gnt | (host_gnt & host_we);
            if (rx_gnt) begin
                mem_addr  <= rx_addr;
                mem_wdata <= rx_wdata;
            end else if (tx_gnt) begin
                mem_addr  <= tx_addr;
            end else if (host_gnt) begin
                mem_addr  <= host_addr;
                mem_wdata <= host_wdata;
            end

            if (host_gnt || !host_req)
                host_wait_cnt <= 8'd0;
            else if (host_wait_cnt != 8'd255)
                host_wait_cnt <= host_wait_cnt + 8'd1;

            // RX grants leave the round-robin pointer untouched.
            if (tx_gnt)
                last_host <= 1'b0;
            else if (host_gnt)
                last_host <= 1'b1;

            // Memory returns data one cycle after the strobe, so the owner tag
            // rides two stages: grant -> tag_s1 -> rvalid.
            if (tx_gnt)
                tag_s1 <= TAG_TX;
            else if (host_gnt && !host_we)
                tag_s1 <= TAG_HOST;
            else
                tag_s1 <= TAG_NONE;
            tx_rvalid   <= (tag_s1 == TAG_TX);
            host_rvalid <= (tag_s1 == TAG_HOST);
        end
    end

    assign rd_data = mem_rdata;

endmodule

// File: doc/packet_mem_arbiter.md
PACKET_MEM_ARBITER -- requirements
Module: packet_mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 15, packet-memory word address width; DATA_W, 16, memory word width; HOST_MAX_WAIT, 8, host starvation limit in cycles (1..255).
REQ-002 Ports SHALL be, clock and reset first (name  direction  width  meaning):
- CLK  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_req, tx_req, host_req  in  1 each  access request, held until granted.
- rx_addr, tx_addr, host_addr  in  ADDR_W each  word address.
- rx_wdata, host_wdata  in  DATA_W each  write data.
- host_we  in  1  host access is a write when 1, a read when 0.
- rx_gnt, tx_gnt, host_gnt  out  1 each  combinational grant, accepted this cycle.
- mem_en, mem_we  out  1 each  registered memory strobe and write enable.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0.
- rd_data  out  DATA_W  mem_rdata, passed through.
- tx_rvalid, host_rvalid  out  1 each  registered; read data valid on rd_data for that requester.

Function
REQ-003 RX accesses SHALL always be writes and TX accesses always reads; host direction SHALL follow host_we.
REQ-004 At most one grant SHALL be high per cycle; a grant SHALL be high only while its req is high.
REQ-005 An access SHALL be accepted in any cycle where req and gnt are both high; the requester then presents its next access or drops req in the following cycle.
REQ-006 Priority SHALL be: (1) host, if host_wait_cnt >= HOST_MAX_WAIT; (2) RX; (3) TX/host round-robin; the last-served flag SHALL toggle only on a TX or host grant and reset to "host served", so TX wins the first tie.
REQ-007 host_wait_cnt (8-bit) SHALL increment each cycle host_req=1 and host_gnt=0, saturate at 255, and clear on host_gnt or host_req=0.
REQ-008 On the clock edge ending an accepted cycle N, mem_en=1 and mem_we/mem_addr/mem_wdata SHALL take the granted requester's values; in cycles with no grant, mem_en=0 and mem_we=0, with addr/wdata holding.
REQ-009 For a read accepted in cycle N, the matching rvalid SHALL be high for exactly cycle N+2, with rd_data = mem_rdata; latency is fixed and independent of other traffic.
REQ-010 Back-to-back grants SHALL be possible every cycle, with full throughput; memory access order SHALL equal grant order, so a read after a write to the same address returns the new data.
REQ-011 A 2-stage tag pipeline SHALL track the owner of each read (none/TX/host); write accesses SHALL produce no rvalid.
REQ-012 With all three requests high continuously, RX SHALL win every cycle except when the host has reached its starvation limit; TX may starve under continuous RX traffic, and this is accepted behaviour.
REQ-013 A requester changing addr/wdata while req=1 and gnt=0 SHALL be allowed; the values at acceptance are used.

Reset
REQ-014 While reset_n=0, asynchronously: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, tx_rvalid=0, host_rvalid=0, tag pipeline cleared, host_wait_cnt=0, last-served=host.
REQ-015 Grants SHALL be forced to 0 while reset_n=0.
REQ-016 Reads in flight when reset asserts SHALL be discarded, and no rvalid SHALL appear after reset release for them.
REQ-017 Deassertion SHALL be synchronised externally; the first grant is possible in the first cycle with reset_n=1.

Verification
REQ-018 Single TX read: memory preloaded with addr 25 = 16'hA55A; tx_req with tx_addr=25 -> tx_gnt in same cycle, mem_en/mem_addr=25 next cycle, tx_rvalid=1 with rd_data=16'hA55A two cycles after grant, for exactly 1 cycle.
REQ-019 RX write then host read of the same address: rx_wdata=16'h1234 to addr 58, then host read of addr 58 -> host_rvalid with rd_data=16'h1234.
REQ-020 rx_req, tx_req and host_req held continuously with HOST_MAX_WAIT=8 -> rx_gnt for 8 cycles, host_gnt on the 9th, then RX again; tx_gnt never asserts.
REQ-021 tx_req and host_req (read) held, RX idle -> grants alternate TX, host, TX, host; rvalids follow the same alternation at 2-cycle latency, one per cycle.
REQ-022 reset_n pulled low the cycle after a host read is granted -> mem_en and all rvalid go 0 immediately, no host_rvalid after release, and the next host_req is granted in the first cycle after release.
